// File: rtl/mem_arbiter_if.sv
// Bus bundle between the arbiter, the two cache requesters and the RAM.
//   Cache side : iREN/iaddr/iwait/iload (instruction), dREN/dWEN/daddr/
//                dstore/dwait/dload (data).
//   RAM side   : ramREN/ramWEN/ramaddr/ramstore (request), ramload/ramstate
//                (response; ramstate 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR).
// modport slave  : the arbiter's view.
// modport master : the environment's view (caches plus RAM).
interface mem_arbiter_if;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: shares one RAM port between an icache and a
// dcache. Data requests normally win, but after STARVE_LIMIT consecutive data
// completions with an instruction request waiting, the instruction side is
// granted next. Grants are registered; request fields pass straight through
// to the RAM while granted.
// Ports:
//   CLK  : clock, rising edge.
//   RST  : asynchronous, active-high reset.
//   bus  : mem_arbiter_if.slave (cache requests/responses and RAM port).
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic          CLK,
    input  logic          RST,
    mem_arbiter_if.slave  bus
);

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [3:0] LIMIT      = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        INSTR = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] starve_q, starve_d;
    logic       d_req;
    logic       d_read;
    logic       starved;
    logic       d_done;
    logic       i_done;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        bus.iwait    = 1'b1;
        bus.dwait    = 1'b1;
        bus.iload    = '0;
        bus.dload    = '0;
        d_done       = 1'b0;
        i_done       = 1'b0;
        d_req        = bus.dREN | bus.dWEN;
        // A simultaneous read and write request is treated as a write.
        d_read       = bus.dREN & ~bus.dWEN;
        starved      = bus.iREN && (starve_q == LIMIT);

        case (state_q)
            IDLE: begin
                if (d_req && !starved) begin
                    state_d = DATA;
                end else if (bus.iREN) begin
                    state_d = INSTR;
                end
            end
            DATA: begin
                bus.ramaddr  = bus.daddr;
                bus.ramWEN   = bus.dWEN;
                bus.ramREN   = d_read;
                bus.ramstore = bus.dstore;
                // A withdrawn request aborts silently; FREE/BUSY/ERROR hold.
                if (!d_req) begin
                    state_d = IDLE;
                end else if (bus.ramstate == RAM_ACCESS) begin
                    d_done    = 1'b1;
                    bus.dwait = 1'b0;
                    bus.dload = d_read ? bus.ramload : '0;
                    state_d   = IDLE;
                end
            end
            INSTR: begin
                bus.ramaddr = bus.iaddr;
                bus.ramREN  = 1'b1;
                if (!bus.iREN) begin
                    state_d = IDLE;
                end else if (bus.ramstate == RAM_ACCESS) begin
                    i_done    = 1'b1;
                    bus.iwait = 1'b0;
                    bus.iload = bus.ramload;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Counts data completions the waiting instruction side has sat through.
        starve_d = starve_q;
        if (!bus.iREN || i_done) begin
            starve_d = '0;
        end else if (d_done && (starve_q < LIMIT)) begin
            starve_d = starve_q + 4'd1;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int LIMIT = 4;

    logic CLK = 1'b0;
    logic RST;

    mem_arbiter_if bus ();

    mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;

    // Reference model: who currently holds the RAM (0 none, 1 dcache, 2 icache)
    // and how many data completions the icache has waited through.
    int owner  = 0;
    int waited = 0;
    int n_ddone = 0;
    int n_idone = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Checks all outputs at the falling edge against the model, then advances
    // the model across the next rising edge. Returns 1ns after that edge.
    task automatic check_cycle();
        logic [31:0] e_addr, e_store, e_iload, e_dload;
        logic        e_ren, e_wen, ddone, idone, rd;
        int          nxt_owner, nxt_waited;
        @(negedge CLK);
        e_addr = 0; e_store = 0; e_ren = 0; e_wen = 0;
        ddone = 0; idone = 0; e_iload = 0; e_dload = 0;
        rd = bus.dREN && !bus.dWEN;
        if (owner == 1) begin
            e_addr  = bus.daddr;
            e_store = bus.dstore;
            e_wen   = bus.dWEN;
            e_ren   = rd;
            ddone   = (bus.dREN || bus.dWEN) && bus.ramstate == 2'd2;
            if (ddone && rd) e_dload = bus.ramload;
        end else if (owner == 2) begin
            e_addr  = bus.iaddr;
            e_ren   = 1;
            idone   = bus.iREN && bus.ramstate == 2'd2;
            if (idone) e_iload = bus.ramload;
        end
        chk("ramREN",   bus.ramREN,   e_ren);
        chk("ramWEN",   bus.ramWEN,   e_wen);
        chk("ramaddr",  bus.ramaddr,  e_addr);
        chk("ramstore", bus.ramstore, e_store);
        chk("dwait",    bus.dwait,    !ddone);
        chk("iwait",    bus.iwait,    !idone);
        chk("dload",    bus.dload,    e_dload);
        chk("iload",    bus.iload,    e_iload);
        if (ddone) n_ddone++;
        if (idone) n_idone++;

        if (owner == 1) begin
            nxt_owner = (ddone || !(bus.dREN || bus.dWEN)) ? 0 : 1;
        end else if (owner == 2) begin
            nxt_owner = (idone || !bus.iREN) ? 0 : 2;
        end else if ((bus.dREN || bus.dWEN) && !(bus.iREN && waited == LIMIT)) begin
            nxt_owner = 1;
        end else begin
            nxt_owner = bus.iREN ? 2 : 0;
        end

        if (!bus.iREN || idone) nxt_waited = 0;
        else if (ddone)         nxt_waited = (waited + 1 > LIMIT) ? LIMIT : waited + 1;
        else                    nxt_waited = waited;

        @(posedge CLK);
        #1;
        owner  = nxt_owner;
        waited = nxt_waited;
    endtask

    task automatic clear_inputs();
        bus.iREN = 0; bus.iaddr = 0; bus.dREN = 0; bus.dWEN = 0;
        bus.daddr = 0; bus.dstore = 0; bus.ramload = 0; bus.ramstate = 2'd0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ramREN"},   bus.ramREN,   0);
        chk({tag, "_ramWEN"},   bus.ramWEN,   0);
        chk({tag, "_ramaddr"},  bus.ramaddr,  0);
        chk({tag, "_ramstore"}, bus.ramstore, 0);
        chk({tag, "_iwait"},    bus.iwait,    1);
        chk({tag, "_dwait"},    bus.dwait,    1);
        chk({tag, "_iload"},    bus.iload,    0);
        chk({tag, "_dload"},    bus.dload,    0);
    endtask

    initial begin
        int k;
        int snap;

        // Reset with requests already pending: outputs must sit at reset values.
        clear_inputs();
        RST = 1;
        bus.iREN = 1; bus.dREN = 1; bus.iaddr = 32'h10; bus.daddr = 32'h20;
        bus.ramstate = 2'd2; bus.ramload = 32'h5555AAAA;
        #1;
        chk_reset_outputs("reset");
        @(posedge CLK); #1;
        chk_reset_outputs("reset_edge");
        clear_inputs();
        RST = 0;
        owner = 0; waited = 0;
        check_cycle();

        // Single instruction read.
        bus.iREN = 1; bus.iaddr = 32'h40;
        check_cycle();
        chk("i_grant_ren",  bus.ramREN,  1);
        chk("i_grant_addr", bus.ramaddr, 32'h40);
        bus.ramstate = 2'd2; bus.ramload = 32'hDEADBEEF;
        #1;
        chk("i_done_iwait", bus.iwait, 0);
        chk("i_done_iload", bus.iload, 32'hDEADBEEF);
        check_cycle();
        bus.iREN = 0; bus.ramstate = 2'd0;
        chk("i_after_idle", bus.ramREN, 0);
        check_cycle();

        // Data write and instruction read raised together: data first.
        bus.iREN = 1; bus.iaddr = 32'h44; bus.dWEN = 1; bus.daddr = 32'h80; bus.dstore = 32'h1234;
        check_cycle();
        chk("dw_wen",   bus.ramWEN,   1);
        chk("dw_ren",   bus.ramREN,   0);
        chk("dw_store", bus.ramstore, 32'h1234);
        chk("dw_addr",  bus.ramaddr,  32'h80);
        bus.ramstate = 2'd2;
        #1;
        chk("dw_dwait", bus.dwait, 0);
        check_cycle();
        bus.dWEN = 0; bus.ramstate = 2'd0;
        chk("dw_gap_idle", bus.ramREN, 0);
        check_cycle();
        chk("dw_then_instr", bus.ramaddr, 32'h44);
        bus.ramstate = 2'd2; bus.ramload = 32'h0BADF00D;
        check_cycle();
        bus.iREN = 0; bus.ramstate = 2'd0;
        check_cycle();

        // Starvation: both sides held, RAM always ready.
        n_ddone = 0; n_idone = 0;
        bus.iREN = 1; bus.iaddr = 32'h300; bus.dREN = 1; bus.daddr = 32'h400;
        bus.ramstate = 2'd2; bus.ramload = 32'h77;
        k = 0;
        while (n_idone == 0 && k < 40) begin check_cycle(); k++; end
        chk("starve_first_data", n_ddone, LIMIT);
        chk("starve_first_instr", n_idone, 1);
        k = 0;
        while (n_idone < 2 && k < 40) begin check_cycle(); k++; end
        chk("starve_second_data", n_ddone, 2 * LIMIT);
        bus.iREN = 0; bus.dREN = 0; bus.ramstate = 2'd0;
        check_cycle();
        check_cycle();

        // ERROR retries then ACCESS on a data read.
        bus.dREN = 1; bus.daddr = 32'h100;
        check_cycle();
        bus.ramstate = 2'd3;
        for (int i = 0; i < 3; i++) begin
            chk("err_dwait", bus.dwait, 1);
            chk("err_addr",  bus.ramaddr, 32'h100);
            chk("err_ren",   bus.ramREN, 1);
            check_cycle();
        end
        bus.ramstate = 2'd2; bus.ramload = 32'hCAFE;
        #1;
        chk("err_done_dwait", bus.dwait, 0);
        chk("err_done_dload", bus.dload, 32'hCAFE);
        check_cycle();
        bus.dREN = 0; bus.ramstate = 2'd0;
        check_cycle();

        // Data request withdrawn while RAM busy.
        bus.dREN = 1; bus.daddr = 32'h500; bus.ramstate = 2'd1;
        check_cycle();
        check_cycle();
        bus.dREN = 0;
        #1;
        chk("drop_dwait", bus.dwait, 1);
        check_cycle();
        chk("drop_idle_addr", bus.ramaddr, 0);
        chk("drop_idle_ren",  bus.ramREN, 0);
        check_cycle();

        // Reset pulse between edges in the middle of an instruction access.
        bus.iREN = 1; bus.iaddr = 32'h200; bus.ramstate = 2'd1;
        check_cycle();
        chk("rst_pre_ren", bus.ramREN, 1);
        #1 RST = 1;
        bus.ramstate = 2'd2; bus.ramload = 32'h99;
        #1;
        chk_reset_outputs("rst_mid");
        #1 RST = 0;
        owner = 0; waited = 0;
        bus.ramstate = 2'd0;
        check_cycle();
        chk("rst_regrant_addr", bus.ramaddr, 32'h200);
        bus.ramstate = 2'd2;
        check_cycle();
        bus.iREN = 0; bus.ramstate = 2'd0;
        check_cycle();

        // Randomized traffic with sticky requests and random RAM behaviour.
        for (int c = 0; c < 400; c++) begin
            if (!bus.iREN) bus.iREN = ($urandom_range(0, 2) == 0);
            else if ($urandom_range(0, 11) == 0) bus.iREN = 0;
            if (!(bus.dREN || bus.dWEN)) begin
                if ($urandom_range(0, 1) == 0) begin
                    bus.dREN = 1'($urandom_range(0, 1));
                    bus.dWEN = 1'($urandom_range(0, 1));
                end
            end else if ($urandom_range(0, 11) == 0) begin
                bus.dREN = 0; bus.dWEN = 0;
            end
            bus.iaddr    = $urandom;
            bus.daddr    = $urandom;
            bus.dstore   = $urandom;
            bus.ramload  = $urandom;
            bus.ramstate = 2'($urandom_range(0, 3));
            snap = c;
            check_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 4, consecutive data completions allowed while an instruction request waits (range 1..15).
REQ-002 CLK  in  1  system clock; all state updates on rising edge.
REQ-003 RST  in  1  reset, asynchronous, active-high.
REQ-004 iREN  in  1  icache read request.
REQ-005 iaddr  in  32  icache word address.
REQ-006 dREN  in  1  dcache read request.
REQ-007 dWEN  in  1  dcache write request.
REQ-008 daddr  in  32  dcache word address.
REQ-009 dstore  in  32  dcache write data.
REQ-010 iwait  out  1  low only in the cycle an instruction access completes.
REQ-011 dwait  out  1  low only in the cycle a data access completes.
REQ-012 iload  out  32  instruction read data, valid when iwait low.
REQ-013 dload  out  32  data read data, valid when dwait low after a read.
REQ-014 ramREN  out  1  RAM read enable.
REQ-015 ramWEN  out  1  RAM write enable.
REQ-016 ramaddr  out  32  RAM address.
REQ-017 ramstore  out  32  RAM write data.
REQ-018 ramload  in  32  RAM read data.
REQ-019 ramstate  in  2  RAM status: 0 FREE, 1 BUSY, 2 ACCESS (done this cycle), 3 ERROR.

Function
REQ-020 FSM states IDLE, DATA, INSTR; RAM outputs driven only in DATA/INSTR; ramREN=ramWEN=0, ramaddr=ramstore=0 in IDLE.
REQ-021 IDLE: (dREN|dWEN) and not starved -> DATA; else iREN -> INSTR; else stay; grant registered, so RAM enables assert one cycle after request.
REQ-022 Starved = iREN high and starve counter == STARVE_LIMIT; starved in IDLE -> INSTR even if data pending.
REQ-023 DATA: ramaddr=daddr, ramWEN=dWEN, ramREN=dREN&~dWEN (write wins when both high), ramstore=dstore.
REQ-024 INSTR: ramaddr=iaddr, ramREN=1, ramWEN=0, ramstore=0.
REQ-025 ramstate ACCESS in DATA: dwait=0, dload=ramload if read else 0, next IDLE.
REQ-026 ramstate ACCESS in INSTR: iwait=0, iload=ramload, next IDLE.
REQ-027 ramstate FREE/BUSY/ERROR: hold state and outputs; ERROR retries by continuing to drive the same request.
REQ-028 iwait/dwait combinational, 1 in every non-completion cycle; iload/dload 0 outside completion cycle.
REQ-029 Requester drops (DATA with dREN=dWEN=0, or INSTR with iREN=0) before ACCESS: abort to IDLE next edge, no wait deasserted.
REQ-030 Starve counter, width 4: +1 on each data completion while iREN high, saturates at STARVE_LIMIT; cleared on instruction completion or any cycle iREN is low.
REQ-031 Back-to-back: after completion the block spends exactly one IDLE cycle before next grant; minimum two cycles per access.
REQ-032 Request changes (address/data) while granted are passed straight through to RAM; no internal latching.

Reset
REQ-033 RST high: state IDLE, counter 0, ramREN=ramWEN=0, ramaddr=ramstore=0, iwait=dwait=1, iload=dload=0, effective immediately regardless of CLK.
REQ-034 RST asserted mid-access abandons the transaction; no completion signalled; first grant no earlier than first rising edge after RST low.

Verification
REQ-035 iREN=1, iaddr=0x40, ramstate ACCESS at 2nd granted cycle, ramload=0xDEADBEEF -> ramREN=1 ramaddr=0x40 from cycle 1, iwait=0 iload=0xDEADBEEF in completion cycle, then IDLE.
REQ-036 iREN and dWEN raised same cycle, daddr=0x80, dstore=0x1234 -> DATA granted first, ramWEN=1 ramstore=0x1234, dwait=0 on ACCESS, then INSTR granted after one IDLE cycle.
REQ-037 STARVE_LIMIT=4, dREN and iREN held high, ramstate ACCESS every granted cycle -> exactly 4 data completions, then one instruction completion, counter back to 0.
REQ-038 ramstate ERROR 3 cycles then ACCESS during DATA read -> dwait held 1 throughout ERROR, request held stable, dwait=0 on ACCESS cycle.
REQ-039 dREN dropped while in DATA with ramstate BUSY -> ram enables 0 next cycle, state IDLE, dwait never low.
REQ-040 RST pulsed between edges during INSTR access -> outputs at reset values immediately, iwait stays 1, grant resumes after RST low.
